// File: rtl/photonic_switch_sequencer_if.sv
// Configuration, run-control and status bundle for the photonic switch sequencer.
// The master side programs the schedule and controls runs; the slave side is the sequencer.
interface photonic_switch_sequencer_if #(
  parameter int CNT_W  = 7,
  parameter int NCH    = 4,
  parameter int ADDR_W = 3
);
  // schedule table programming
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CNT_W-1:0]  cfg_time;
  logic [NCH-1:0]    cfg_mask;
  // run configuration and control
  logic [ADDR_W:0]   num_steps;
  logic [CNT_W-1:0]  period;
  logic              continuous;
  logic              start;
  logic              stop;
  // sequencer status and switch drive
  logic [NCH-1:0]    sw_out;
  logic [CNT_W-1:0]  cnt;
  logic              step_pulse;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_time, cfg_mask,
    output num_steps, period, continuous, start, stop,
    input  sw_out, cnt, step_pulse, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_time, cfg_mask,
    input  num_steps, period, continuous, start, stop,
    output sw_out, cnt, step_pulse, busy, done, cfg_err
  );
endinterface

// File: rtl/photonic_switch_sequencer.sv
// Programmable timing sequencer for the photonic switch bank.
// A period counter runs while in RUN; whenever it equals the time of the current
// schedule entry, that entry's channel mask is driven onto the switch outputs.
module photonic_switch_sequencer #(
  parameter int CNT_W  = 7,
  parameter int NCH    = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic                     counter_clk,
  input logic                     reset,
  photonic_switch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t state_reg, state_next;

  // schedule table, one {time, mask} register per entry
  logic [CNT_W-1:0] time_mem [DEPTH];
  logic [NCH-1:0]   mask_mem [DEPTH];

  // run state and latched run configuration
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [ADDR_W:0]  idx_reg;
  logic [ADDR_W:0]  nsteps_reg;
  logic             cont_reg;
  logic [NCH-1:0]   sw_reg;
  logic             step_reg;
  logic             done_reg;
  logic             err_reg;

  // decoded control for the current cycle
  logic             cfg_phase;
  logic             in_run;
  logic             start_req;
  logic             cfg_ok;
  logic             launch;
  logic             bad_start;
  logic             table_we;
  logic             run_go;
  logic             wrap;
  logic             idx_live;
  logic             sched_end;
  logic             fire;
  logic             skip;
  logic             restart;
  logic             finish;
  logic [CNT_W-1:0] entry_time;
  logic [NCH-1:0]   entry_mask;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [CNT_W+NCH-1:0] entry_reg;

    // Entry storage: written only outside RUN so a live schedule never changes under the counter.
    always_ff @(posedge counter_clk or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (table_we && (bus.cfg_addr == ADDR_W'(gi))) begin
        entry_reg <= {bus.cfg_time, bus.cfg_mask};
      end
    end

    assign time_mem[gi] = entry_reg[CNT_W+NCH-1:NCH];
    assign mask_mem[gi] = entry_reg[NCH-1:0];
  end

  // The step index is one bit wider than the table address so it can hold num_steps itself.
  assign entry_time = time_mem[idx_reg[ADDR_W-1:0]];
  assign entry_mask = mask_mem[idx_reg[ADDR_W-1:0]];

  // Decode this cycle's events; a match always wins over any wrap-time action.
  always_comb begin
    cfg_phase = (state_reg != ST_RUN);
    in_run    = (state_reg == ST_RUN);
    start_req = cfg_phase && bus.start && !bus.stop;
    cfg_ok    = (bus.period != '0) && (bus.num_steps != '0) && (bus.num_steps <= DEPTH_V);
    launch    = start_req && cfg_ok;
    bad_start = start_req && !cfg_ok;
    table_we  = cfg_phase && bus.cfg_we;
    run_go    = in_run && !bus.stop;
    wrap      = (cnt_reg == (period_reg - CNT_W'(1)));
    idx_live  = (idx_reg < nsteps_reg);
    sched_end = (idx_reg == nsteps_reg);
    fire      = run_go && idx_live && (entry_time == cnt_reg);
    skip      = run_go && !fire && wrap && idx_live && (entry_time >= period_reg);
    restart   = run_go && wrap && sched_end && cont_reg;
    finish    = run_go && wrap && sched_end && !cont_reg;
  end

  // State register.
  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: DONE accepts configuration and start exactly like IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (launch) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop)    state_next = ST_IDLE;
        else if (finish) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: busy follows the state, everything else comes straight from registers.
  always_comb begin
    bus.busy       = in_run;
    bus.sw_out     = sw_reg;
    bus.cnt        = cnt_reg;
    bus.step_pulse = step_reg;
    bus.done       = done_reg;
    bus.cfg_err    = err_reg;
  end

  // Counter, step index, switch drive, latched configuration and event pulses.
  always_ff @(posedge counter_clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      idx_reg    <= '0;
      nsteps_reg <= '0;
      cont_reg   <= 1'b0;
      sw_reg     <= '0;
      step_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      step_reg <= fire;
      done_reg <= finish;
      err_reg  <= bad_start || skip || (in_run && bus.cfg_we);

      if (start_req) begin
        period_reg <= bus.period;
        nsteps_reg <= bus.num_steps;
        cont_reg   <= bus.continuous;
      end

      if (launch) begin
        cnt_reg <= '0;
        idx_reg <= '0;
        sw_reg  <= '0;
      end else if (in_run) begin
        if (bus.stop || finish) begin
          cnt_reg <= '0;
          idx_reg <= '0;
          sw_reg  <= '0;
        end else begin
          cnt_reg <= wrap ? '0 : (cnt_reg + CNT_W'(1));
          if (fire) begin
            sw_reg <= entry_mask;
          end
          if (fire || skip) begin
            idx_reg <= idx_reg + (ADDR_W + 1)'(1);
          end else if (restart) begin
            idx_reg <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/photonic_switch_sequencer.md
Name: photonic_switch_sequencer

Overview:
Programmable timing sequencer for the photonic switch bank. It holds a small schedule table of (time, channel mask) entries and runs an internal period counter. When the counter equals the current entry's time, it drives that mask onto the switch outputs. It replaces free-running external counter/comparator pairs with one sequenced, reconfigurable controller clocked by counter_clk.

Parameters:
CNT_W, 7, width of period counter and entry time fields
NCH, 4, number of switch output channels
DEPTH, 8, schedule table entries
ADDR_W, 3, table address width (log2 DEPTH)

Ports:
counter_clk  input  1  sequencer clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
cfg_we  input  1  table write strobe
cfg_addr  input  ADDR_W  table entry index
cfg_time  input  CNT_W  entry match time
cfg_mask  input  NCH  entry switch pattern
num_steps  input  ADDR_W+1  valid entries (1..DEPTH), sampled on start
period  input  CNT_W  counter period in cycles (>=1), sampled on start
continuous  input  1  1 = repeat schedule every period; sampled on start
start  input  1  begin run (level, acted on in IDLE/DONE)
stop  input  1  abort run
sw_out  output  NCH  registered switch drive
cnt  output  CNT_W  current counter value
step_pulse  output  1  one-cycle pulse when an entry fires
busy  output  1  high in RUN
done  output  1  one-cycle pulse on single-shot completion
cfg_err  output  1  one-cycle error pulse

Behaviour:
- Reset (async): state IDLE; sw_out, cnt, step index, latched config, step_pulse, done, cfg_err = 0; all table entries = 0.
- States: IDLE, RUN, DONE. DONE behaves as IDLE for config and start; it differs only for observability.
- Table write: cfg_we in IDLE/DONE writes table[cfg_addr] <= {cfg_time, cfg_mask} at the edge. cfg_we in RUN is ignored and cfg_err pulses.
- Start, IDLE/DONE, stop=0: latch period, num_steps, continuous.
  - If period==0, num_steps==0 or num_steps>DEPTH: cfg_err pulses and state is unchanged.
  - Otherwise go to RUN with cnt=0, idx=0, sw_out=0, busy=1 from the next cycle.
- RUN counter: cnt increments every cycle. At cnt==period_lat-1 it wraps to 0 (the wrap cycle). period_lat=1 keeps cnt at 0.
- Match: in a RUN cycle, if idx<num_steps_lat and table[idx].time==cnt, then at the next edge sw_out <= table[idx].mask, step_pulse=1 for one cycle, and idx++. The latency from the matching cnt to sw_out change is 1 cycle. At most one entry fires per cycle.
- Equal or decreasing entry times: the next entry matches on the next occurrence of its cnt value, possibly in the following period.
- Unreachable entry: at a wrap cycle, if idx<num_steps_lat and table[idx].time>=period_lat, the entry is skipped. idx++, sw_out holds, cfg_err pulses.
- Schedule end, idx==num_steps_lat:
  - continuous=1: at the next wrap, idx<=0 and sw_out holds. The pattern repeats each period.
  - continuous=0: at the next wrap, state becomes DONE, sw_out<=0, cnt<=0, busy<=0 and done pulses one cycle.
- A match and a wrap in the same cycle: the match fires. The end-of-schedule action is taken at the next wrap, never the same one.
- stop in RUN: at the next edge, state IDLE, sw_out=0, cnt=0, idx=0, busy=0, no done. stop together with start: stop wins; start is ignored that cycle.
- start held high in RUN is ignored. A run starts only from IDLE/DONE.
- Reset mid-RUN: outputs drop to 0 immediately (async) and the table is cleared.

Test Plan:
- Reset, write entries {t=3,m=0001},{t=10,m=0110}, period=20, num_steps=2, continuous=0, start → sw_out=0001 from the cycle after cnt==3, then 0110 after cnt==10; done pulses when cnt wraps at 19; sw_out=0, busy=0 afterwards.
- Same table with continuous=1 → the 0001/0110 pattern repeats every 20 cycles and step_pulse occurs twice per period; stop at cnt=15 → sw_out=0 and busy=0 next cycle, no done.
- cfg_we during RUN at addr 0 with t=5 → cfg_err pulse; the entry keeps t=3 on the next run.
- Entry 0 t=25 with period=20, num_steps=1 → no sw_out change; cfg_err at the first wrap; done at the second wrap.
- start with num_steps=0, or with period=0 → cfg_err one cycle, state stays IDLE, busy=0.
- Assert reset asynchronously mid-cycle during RUN with sw_out=0110 → sw_out, cnt, busy = 0 before the next edge; all table entries read back 0, verified by a run with t=0 entries firing mask 0 at cnt=0.
